// File: rtl/mem_access_stage.sv
// MEM stage of the MIPS core: ALU result pass-through plus load/store execution on a
// request/ack data bus, with big-endian lane selection, load extension and misalignment flagging.
module mem_access_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        ex_reg_write_enable,
  input  logic [4:0]  ex_reg_write_address,
  input  logic [31:0] ex_reg_write_data,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [31:0] dbus_read_data,
  input  logic        dbus_ack,
  output logic        dbus_request,
  output logic        dbus_write,
  output logic [31:0] dbus_address,
  output logic [3:0]  dbus_byte_select,
  output logic [31:0] dbus_write_data,
  output logic        mem_reg_write_enable,
  output logic [4:0]  mem_reg_write_address,
  output logic [31:0] mem_reg_write_data,
  output logic        stall_request,
  output logic        address_error
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t      state;
  logic [31:0] hold_data;

  logic        is_load;
  logic        is_store;
  logic        size_byte;
  logic        size_half;
  logic        sign_ext;
  logic        misaligned;
  logic        access_ok;
  logic        bus_active;
  logic [1:0]  off;
  logic [31:0] load_src;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic        unused_stall_bits;

  function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = b;
    sw = sb;
    return sgn ? sw : {24'd0, b};
  endfunction

  function automatic logic [31:0] extend_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = h;
    sw = sh;
    return sgn ? sw : {16'd0, h};
  endfunction

  assign off               = mem_address[1:0];
  assign unused_stall_bits = ^{stall[5], stall[3:0]};

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size_byte = 1'b0;
    size_half = 1'b0;
    case (mem_op)
      OP_LB, OP_LBU: begin is_load = 1'b1;  size_byte = 1'b1; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  size_half = 1'b1; end
      OP_LW:         begin is_load = 1'b1; end
      OP_SB:         begin is_store = 1'b1; size_byte = 1'b1; end
      OP_SH:         begin is_store = 1'b1; size_half = 1'b1; end
      OP_SW:         begin is_store = 1'b1; end
      default: ;
    endcase
  end

  assign sign_ext   = (mem_op == OP_LB) || (mem_op == OP_LH);
  assign misaligned = (is_load | is_store) &
                      ((size_half & off[0]) | (~size_byte & ~size_half & (off != 2'b00)));
  assign access_ok  = (is_load | is_store) & ~misaligned;
  // In HOLD the access already completed; re-issuing would duplicate a store.
  assign bus_active = access_ok & (state != S_HOLD);

  always_comb begin
    load_src = (state == S_HOLD) ? hold_data : dbus_read_data;
    case (off)
      2'd0:    load_byte = load_src[31:24];
      2'd1:    load_byte = load_src[23:16];
      2'd2:    load_byte = load_src[15:8];
      default: load_byte = load_src[7:0];
    endcase
    load_half = off[1] ? load_src[15:0] : load_src[31:16];
    if (size_byte)
      load_value = extend_byte(load_byte, sign_ext);
    else if (size_half)
      load_value = extend_half(load_half, sign_ext);
    else
      load_value = load_src;
  end

  always_comb begin
    dbus_request          = 1'b0;
    dbus_write            = 1'b0;
    dbus_address          = 32'd0;
    dbus_byte_select      = 4'd0;
    dbus_write_data       = 32'd0;
    mem_reg_write_enable  = 1'b0;
    mem_reg_write_address = 5'd0;
    mem_reg_write_data    = 32'd0;
    stall_request         = 1'b0;
    address_error         = 1'b0;
    if (!reset) begin
      dbus_request  = bus_active;
      dbus_write    = bus_active & is_store;
      dbus_address  = {mem_address[31:2], 2'b00};
      if (bus_active) begin
        if (is_store && size_byte) begin
          dbus_byte_select = 4'b1000 >> off;
          dbus_write_data  = {4{mem_store_data[7:0]}};
        end else if (is_store && size_half) begin
          dbus_byte_select = off[1] ? 4'b0011 : 4'b1100;
          dbus_write_data  = {2{mem_store_data[15:0]}};
        end else begin
          dbus_byte_select = 4'b1111;
          dbus_write_data  = is_store ? mem_store_data : 32'd0;
        end
      end
      mem_reg_write_enable  = ex_reg_write_enable & ~misaligned;
      mem_reg_write_address = ex_reg_write_address;
      mem_reg_write_data    = is_load ? load_value : ex_reg_write_data;
      stall_request         = bus_active & ~dbus_ack;
      address_error         = misaligned;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      hold_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE, S_WAIT: begin
          if (access_ok && dbus_ack) begin
            if (stall[4]) begin
              state     <= S_HOLD;
              hold_data <= dbus_read_data;
            end else begin
              state <= S_IDLE;
            end
          end else if (access_ok) begin
            state <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HOLD:  if (!stall[4]) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a behavioural model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_mem_access_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  stall;
  logic        ex_reg_write_enable;
  logic [4:0]  ex_reg_write_address;
  logic [31:0] ex_reg_write_data;
  logic [3:0]  mem_op;
  logic [31:0] mem_address;
  logic [31:0] mem_store_data;
  logic [31:0] dbus_read_data;
  logic        dbus_ack;
  logic        dbus_request;
  logic        dbus_write;
  logic [31:0] dbus_address;
  logic [3:0]  dbus_byte_select;
  logic [31:0] dbus_write_data;
  logic        mem_reg_write_enable;
  logic [4:0]  mem_reg_write_address;
  logic [31:0] mem_reg_write_data;
  logic        stall_request;
  logic        address_error;

  mem_access_stage dut (
    .clock(clock), .reset(reset), .stall(stall),
    .ex_reg_write_enable(ex_reg_write_enable),
    .ex_reg_write_address(ex_reg_write_address),
    .ex_reg_write_data(ex_reg_write_data),
    .mem_op(mem_op), .mem_address(mem_address), .mem_store_data(mem_store_data),
    .dbus_read_data(dbus_read_data), .dbus_ack(dbus_ack),
    .dbus_request(dbus_request), .dbus_write(dbus_write), .dbus_address(dbus_address),
    .dbus_byte_select(dbus_byte_select), .dbus_write_data(dbus_write_data),
    .mem_reg_write_enable(mem_reg_write_enable),
    .mem_reg_write_address(mem_reg_write_address),
    .mem_reg_write_data(mem_reg_write_data),
    .stall_request(stall_request), .address_error(address_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cnt_stall = 0;
  int cnt_done = 0;
  int cnt_store = 0;
  int s0, d0, w0;

  // Model state: a completed access parked because MEM/WB is held.
  bit          m_held = 1'b0;
  logic [31:0] m_hdata = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int op_size(input logic [3:0] op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    return 4;
  endfunction

  function automatic bit op_access(input logic [3:0] op);
    return op >= 1 && op <= 8;
  endfunction

  function automatic bit op_mis(input logic [3:0] op, input logic [31:0] a);
    return op_access(op) && ((a % op_size(op)) != 0);
  endfunction

  task automatic model_check();
    logic [31:0] e_sel, e_wd, e_data, e_addr, src, v;
    bit          e_req, e_wr, e_stall, e_err, e_wen, ld, st, mis;
    int          off, sz;
    logic [4:0]  e_wa;
    e_sel = 0; e_wd = 0; e_data = 0; e_addr = 0;
    e_req = 0; e_wr = 0; e_stall = 0; e_err = 0; e_wen = 0; e_wa = 0;
    mis = op_mis(mem_op, mem_address);
    if (!reset) begin
      ld  = mem_op >= 1 && mem_op <= 5;
      st  = mem_op >= 6 && mem_op <= 8;
      sz  = op_size(mem_op);
      off = int'(mem_address % 4);
      e_req   = op_access(mem_op) && !mis && !m_held;
      e_wr    = e_req && st;
      e_stall = e_req && !dbus_ack;
      e_err   = mis;
      e_wen   = ex_reg_write_enable && !mis;
      e_wa    = ex_reg_write_address;
      e_addr  = mem_address & 32'hFFFF_FFFC;
      if (e_req) begin
        if (ld || sz == 4) e_sel = 32'hF;
        else if (sz == 1) e_sel = 32'h1 << (3 - off);
        else e_sel = (off == 0) ? 32'hC : 32'h3;
        if (st) begin
          if (sz == 1) e_wd = (mem_store_data & 32'hFF) * 32'h0101_0101;
          else if (sz == 2) e_wd = (mem_store_data & 32'hFFFF) * 32'h0001_0001;
          else e_wd = mem_store_data;
        end
      end
      if (ld) begin
        src = m_held ? m_hdata : dbus_read_data;
        if (sz == 1) begin
          v = (src >> (8 * (3 - off))) & 32'hFF;
          if (mem_op == 1 && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (sz == 2) begin
          v = (src >> (8 * (2 - off))) & 32'hFFFF;
          if (mem_op == 3 && v >= 32768) v = v | 32'hFFFF_0000;
        end else begin
          v = src;
        end
        e_data = v;
      end else begin
        e_data = ex_reg_write_data;
      end
    end
    chk("m_request", dbus_request, e_req);
    chk("m_write", dbus_write, e_wr);
    chk("m_address", dbus_address, e_addr);
    chk("m_byte_select", dbus_byte_select, e_sel);
    chk("m_write_data", dbus_write_data, e_wd);
    chk("m_stall_request", stall_request, e_stall);
    chk("m_address_error", address_error, e_err);
    chk("m_wb_enable", mem_reg_write_enable, e_wen);
    chk("m_wb_address", mem_reg_write_address, e_wa);
    if (reset || !mis) chk("m_wb_data", mem_reg_write_data, e_data);
  endtask

  task automatic model_update();
    if (reset) begin
      m_held  = 1'b0;
      m_hdata = 32'd0;
    end else if (m_held) begin
      if (!stall[4]) m_held = 1'b0;
    end else if (op_access(mem_op) && !op_mis(mem_op, mem_address) && dbus_ack && stall[4]) begin
      m_held  = 1'b1;
      m_hdata = dbus_read_data;
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    model_check();
    if (dbus_request && !dbus_ack) cnt_stall++;
    if (dbus_request && dbus_ack) cnt_done++;
    if (dbus_request && dbus_ack && dbus_write) cnt_store++;
  endtask

  task automatic adv();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input logic ack, input logic st4);
    mem_op         = op;
    mem_address    = a;
    mem_store_data = sd;
    dbus_read_data = rd;
    dbus_ack       = ack;
    stall          = st4 ? 6'b010000 : 6'b000000;
  endtask

  initial begin
    reset = 1'b1;
    ex_reg_write_enable  = 1'b1;
    ex_reg_write_address = 5'd7;
    ex_reg_write_data    = 32'hCAFE_0001;
    drive(4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc();
    chk("reset_wb_enable", mem_reg_write_enable, 0);
    chk("reset_wb_data", mem_reg_write_data, 0);
    adv();
    reset = 1'b0;

    // zero-wait LW
    drive(4'd5, 32'h100, 32'h0, 32'h8899_AABB, 1'b1, 1'b0);
    cyc();
    chk("lw_data", mem_reg_write_data, 32'h8899_AABB);
    chk("lw_stall", stall_request, 0);
    chk("lw_req", dbus_request, 1);
    adv();

    drive(4'd1, 32'h103, 32'h0, 32'h0000_00F0, 1'b1, 1'b0);
    cyc(); chk("lb_data", mem_reg_write_data, 32'hFFFF_FFF0); adv();
    drive(4'd2, 32'h103, 32'h0, 32'h0000_00F0, 1'b1, 1'b0);
    cyc(); chk("lbu_data", mem_reg_write_data, 32'h0000_00F0); adv();
    drive(4'd3, 32'h102, 32'h0, 32'h0000_8001, 1'b1, 1'b0);
    cyc(); chk("lh_data", mem_reg_write_data, 32'hFFFF_8001); adv();
    drive(4'd4, 32'h100, 32'h0, 32'h8001_1234, 1'b1, 1'b0);
    cyc(); chk("lhu_data", mem_reg_write_data, 32'h0000_8001); adv();

    drive(4'd6, 32'h101, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    cyc();
    chk("sb_sel", dbus_byte_select, 4'b0100);
    chk("sb_wdata", dbus_write_data, 32'h7878_7878);
    chk("sb_addr", dbus_address, 32'h100);
    chk("sb_write", dbus_write, 1);
    adv();
    drive(4'd7, 32'h102, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    cyc();
    chk("sh_sel", dbus_byte_select, 4'b0011);
    chk("sh_wdata", dbus_write_data, 32'h5678_5678);
    adv();

    drive(4'd0, 32'h104, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(); chk("none_data", mem_reg_write_data, 32'hCAFE_0001); adv();
    drive(4'd9, 32'h104, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(); chk("op9_req", dbus_request, 0); adv();

    // LW with 3-cycle ack latency
    s0 = cnt_stall; d0 = cnt_done;
    for (int i = 0; i < 3; i++) begin
      drive(4'd5, 32'h200, 32'h0, 32'hDEAD_0000, 1'b0, 1'b0);
      cyc(); adv();
    end
    drive(4'd5, 32'h200, 32'h0, 32'h1122_3344, 1'b1, 1'b0);
    cyc();
    chk("lwd_stall_ack", stall_request, 0);
    chk("lwd_data", mem_reg_write_data, 32'h1122_3344);
    adv();
    chk("lwd_stall_cycles", cnt_stall - s0, 3);
    chk("lwd_transactions", cnt_done - d0, 1);

    // SW completing while MEM/WB is held
    w0 = cnt_store;
    drive(4'd8, 32'h300, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);
    cyc();
    chk("sw_sel", dbus_byte_select, 4'hF);
    chk("sw_wdata", dbus_write_data, 32'hDEAD_BEEF);
    adv();
    for (int i = 0; i < 2; i++) begin
      drive(4'd8, 32'h300, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);
      cyc(); chk("sw_hold_req", dbus_request, 0); adv();
    end
    drive(4'd8, 32'h300, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);
    cyc(); chk("sw_release_req", dbus_request, 0); adv();
    chk("sw_store_count", cnt_store - w0, 1);
    drive(4'd5, 32'h304, 32'h0, 32'h0BAD_F00D, 1'b1, 1'b0);
    cyc(); chk("after_hold_req", dbus_request, 1); adv();

    // LW completing while held: result must come from the captured data
    drive(4'd5, 32'h400, 32'h0, 32'hA5A5_0F0F, 1'b1, 1'b1);
    cyc(); adv();
    drive(4'd5, 32'h400, 32'h0, 32'h0000_0000, 1'b0, 1'b1);
    cyc();
    chk("lw_hold_data", mem_reg_write_data, 32'hA5A5_0F0F);
    chk("lw_hold_stall", stall_request, 0);
    adv();
    drive(4'd5, 32'h400, 32'h0, 32'h0000_0000, 1'b0, 1'b0);
    cyc(); chk("lw_hold_release_data", mem_reg_write_data, 32'hA5A5_0F0F); adv();

    // misaligned accesses
    drive(4'd5, 32'h102, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc();
    chk("mis_lw_err", address_error, 1);
    chk("mis_lw_req", dbus_request, 0);
    chk("mis_lw_wen", mem_reg_write_enable, 0);
    adv();
    drive(4'd7, 32'h103, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(); chk("mis_sh_err", address_error, 1); adv();
    drive(4'd3, 32'h101, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(); chk("mis_lh_stall", stall_request, 0); adv();

    // reset while waiting for an ack
    drive(4'd5, 32'h500, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(); chk("wait_stall", stall_request, 1); adv();
    reset = 1'b1;
    #1;
    chk("rst_req", dbus_request, 0);
    chk("rst_stall", stall_request, 0);
    chk("rst_addr", dbus_address, 0);
    chk("rst_wen", mem_reg_write_enable, 0);
    chk("rst_wa", mem_reg_write_address, 0);
    m_held = 1'b0;
    m_hdata = 32'd0;
    cyc(); adv();
    reset = 1'b0;
    drive(4'd5, 32'h600, 32'h0, 32'h5566_7788, 1'b1, 1'b0);
    cyc();
    chk("post_rst_data", mem_reg_write_data, 32'h5566_7788);
    chk("post_rst_req", dbus_request, 1);
    adv();
    drive(4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
